// File: rtl/ps2_keyboard_controller.sv
// ps2_keyboard_controller
//   Receives PS/2 Set-2 scan-code frames, qualifies and deserialises them,
//   folds E0/F0/E1 prefixes into single key events and buffers the events
//   in a 4-entry FIFO with a valid/ready output handshake.
// Ports:
//   clk25m, rst            system clock, async active-high reset
//   clkps2, dataps2        raw PS/2 pins (asynchronous)
//   key_valid/key_ready    head-of-FIFO handshake
//   key_code/key_extended/key_released  head event fields
//   frame_error, overflow  one-cycle error pulses
//   busy                   frame receiver active
module ps2_keyboard_controller #(
  parameter int unsigned FILTER         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 25000
) (
  input  logic       clk25m,
  input  logic       rst,
  input  logic       clkps2,
  input  logic       dataps2,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_released,
  output logic       frame_error,
  output logic       overflow,
  output logic       busy
);

  localparam int unsigned FW = $clog2(FILTER + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  // ---------------- input conditioning ----------------
  logic clk_m, clk_s, dat_m, dat_s;

  always_ff @(posedge clk25m or posedge rst) begin
    if (rst) begin
      clk_m <= 1'b1;
      clk_s <= 1'b1;
      dat_m <= 1'b1;
      dat_s <= 1'b1;
    end else begin
      clk_m <= clkps2;
      clk_s <= clk_m;
      dat_m <= dataps2;
      dat_s <= dat_m;
    end
  end

  logic          clk_f;
  logic [FW-1:0] flt_cnt;
  logic          flt_hit;
  logic          edge_e;

  // The filtered clock flips on the FILTER-th consecutive differing sample.
  assign flt_hit = (clk_s != clk_f) && (flt_cnt == FW'(FILTER - 1));
  assign edge_e  = flt_hit && !clk_s;

  always_ff @(posedge clk25m or posedge rst) begin
    if (rst) begin
      clk_f   <= 1'b1;
      flt_cnt <= '0;
    end else if (clk_s == clk_f) begin
      flt_cnt <= '0;
    end else if (flt_hit) begin
      clk_f   <= clk_s;
      flt_cnt <= '0;
    end else begin
      flt_cnt <= flt_cnt + 1'b1;
    end
  end

  // ---------------- frame receiver ----------------
  typedef enum logic [1:0] {F_IDLE, F_RX, F_CHECK} frame_state_t;

  frame_state_t  f_state, f_next;
  logic [3:0]    bit_cnt;
  logic [9:0]    sr;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          err_set, byte_set, start, shift;
  logic          byte_stb;
  logic [7:0]    byte_val;

  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk25m or posedge rst) begin
    if (rst) f_state <= F_IDLE;
    else     f_state <= f_next;
  end

  always_comb begin
    f_next   = f_state;
    err_set  = 1'b0;
    byte_set = 1'b0;
    start    = 1'b0;
    shift    = 1'b0;
    case (f_state)
      F_IDLE: begin
        if (edge_e) begin
          if (!dat_s) begin
            f_next = F_RX;
            start  = 1'b1;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      F_RX: begin
        if (tmo_hit) begin
          f_next  = F_IDLE;
          err_set = 1'b1;
        end else if (edge_e) begin
          shift = 1'b1;
          if (bit_cnt == 4'd10) f_next = F_CHECK;
        end
      end
      F_CHECK: begin
        f_next = F_IDLE;
        // sr[9] = stop, sr[8] = parity, sr[7:0] = data
        if ((^sr[8:0]) && sr[9]) byte_set = 1'b1;
        else                     err_set  = 1'b1;
      end
      default: f_next = F_IDLE;
    endcase
  end

  always_ff @(posedge clk25m or posedge rst) begin
    if (rst) begin
      bit_cnt     <= '0;
      sr          <= '0;
      tmo_cnt     <= '0;
      frame_error <= 1'b0;
      byte_stb    <= 1'b0;
      byte_val    <= '0;
    end else begin
      if (start) bit_cnt <= 4'd1;
      if (shift) begin
        sr      <= {dat_s, sr[9:1]};
        bit_cnt <= bit_cnt + 4'd1;
      end
      if (edge_e || f_state != F_RX) tmo_cnt <= '0;
      else                           tmo_cnt <= tmo_cnt + 1'b1;
      frame_error <= err_set;
      byte_stb    <= byte_set;
      byte_val    <= sr[7:0];
    end
  end

  assign busy = (f_state != F_IDLE);

  // ---------------- prefix decoder ----------------
  typedef enum logic [2:0] {D_BASE, D_EXT, D_REL, D_EXTREL, D_PAUSE} dec_state_t;

  dec_state_t d_state, d_next;
  logic [2:0] skip_cnt;
  logic       skip_load, skip_dec;
  logic       push;
  logic [9:0] push_data;
  logic       ext_flag, rel_flag, ignored;

  assign ext_flag = (d_state == D_EXT) || (d_state == D_EXTREL);
  assign rel_flag = (d_state == D_REL) || (d_state == D_EXTREL);
  assign ignored  = byte_val inside {8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hFE, 8'hEE};

  always_ff @(posedge clk25m or posedge rst) begin
    if (rst) begin
      d_state  <= D_BASE;
      skip_cnt <= '0;
    end else begin
      d_state <= d_next;
      if (skip_load)     skip_cnt <= 3'd7;
      else if (skip_dec) skip_cnt <= skip_cnt - 3'd1;
    end
  end

  always_comb begin
    d_next    = d_state;
    push      = 1'b0;
    push_data = {byte_val, ext_flag, rel_flag};
    skip_load = 1'b0;
    skip_dec  = 1'b0;
    if (byte_stb) begin
      if (d_state == D_PAUSE) begin
        skip_dec = 1'b1;
        if (skip_cnt == 3'd1) d_next = D_BASE;
      end else if (ignored) begin
        d_next = D_BASE;
      end else if (byte_val == 8'hE0 && !ext_flag) begin
        d_next = rel_flag ? D_EXTREL : D_EXT;
      end else if (byte_val == 8'hF0 && !rel_flag) begin
        d_next = ext_flag ? D_EXTREL : D_REL;
      end else if (byte_val == 8'hE1 && d_state == D_BASE) begin
        push      = 1'b1;
        push_data = {8'hE1, 2'b00};
        skip_load = 1'b1;
        d_next    = D_PAUSE;
      end else begin
        push   = 1'b1;
        d_next = D_BASE;
      end
    end
  end

  // ---------------- event FIFO ----------------
  logic [9:0] mem [4];
  logic [1:0] rd_ptr, wr_ptr;
  logic [2:0] count;
  logic       pop, push_ok;

  assign key_valid = (count != 3'd0);
  assign pop       = key_valid && key_ready;
  // When full, a simultaneous pop frees the slot being written.
  assign push_ok   = push && ((count != 3'd4) || pop);

  always_ff @(posedge clk25m or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) mem[i] <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      case ({push_ok, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      overflow <= push && !push_ok;
    end
  end

  assign {key_code, key_extended, key_released} = mem[rd_ptr];

endmodule
